inst_fetch: RTL and testbench

Front-end fetch stage that owns the architectural fetch PC register and issues in-order word requests to instruction memory. It returns {pc, inst} pairs to decode through a small in-order buffer. It sits directly upstream of the next-PC logic: its `if_pc`/`if_inst` feed that logic, and the taken-branch target produced there comes back as `redirect_valid`/`redirect_pc`. Redirects flush the buffer and discard stale in-flight responses.

---
 rtl/inst_fetch_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 35 +++
 rtl/inst_fetch.sv | 75 +++++++
 tb/tb_inst_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch constants and FSM encoding
package inst_fetch_pkg;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] PC_INCR = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop, flush, count, full and empty
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  assign dout = mem[rptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, in-order imem requests and {pc,inst} buffer to decode; INST_FETCH_BYPASS_EN adds same-cycle response bypass
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  stall,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [31:0]           if_pc,
  input  logic                  if_ready
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int BW = 32 + INST_WIDTH;
  state_t state, state_n;
  logic [31:0] fetch_pc, rsp_pc;
  logic [CW-1:0] inflight, buf_count, discard, discard_n;
  logic [BW-1:0] buf_head;
  logic pend_full, pend_empty, buf_full, buf_empty;
  logic req_fire, rsp_keep, take, bypass, buf_push, buf_pop;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && discard == '0;
  assign take = if_ready && !stall;
`ifdef INST_FETCH_BYPASS_EN
  assign bypass = buf_empty && rsp_keep && take && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  assign buf_push = rsp_keep && !redirect_valid && !bypass;
  assign buf_pop = if_valid && take && !buf_empty;
  assign if_valid = !redirect_valid && (!buf_empty || bypass);
  assign if_pc = if_valid ? (bypass ? rsp_pc : buf_head[BW-1:INST_WIDTH]) : '0;
  assign if_inst = if_valid ? (bypass ? imem_rsp_data : buf_head[INST_WIDTH-1:0]) : '0;
  assign imem_req_addr = fetch_pc;
  assign imem_req_valid = state != BOOT && !stall && !redirect_valid &&
                          ({1'b0, inflight} + {1'b0, buf_count} < (CW+1)'(BUF_DEPTH));
  // a redirect turns every outstanding request, including one answered this cycle, into a discard
  assign discard_n = redirect_valid ? inflight - CW'(imem_rsp_valid)
                                    : discard - CW'(imem_rsp_valid && discard != '0);
  always_comb state_n = (state != BOOT && discard_n != '0) ? FLUSH : RUN;
  always_ff @(posedge clk)
    if (reset) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      discard <= '0;
    end else begin
      state <= state_n;
      discard <= discard_n;
      fetch_pc <= redirect_valid ? (redirect_pc & ~32'h3) : req_fire ? fetch_pc + PC_INCR : fetch_pc;
    end
  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pend (
    .clk(clk), .rst(reset), .push(req_fire), .pop(imem_rsp_valid), .flush(1'b0),
    .din(fetch_pc), .dout(rsp_pc), .count(inflight), .full(pend_full), .empty(pend_empty)
  );
  fetch_fifo #(.WIDTH(BW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk), .rst(reset), .push(buf_push), .pop(buf_pop), .flush(redirect_valid),
    .din({rsp_pc, imem_rsp_data}), .dout(buf_head), .count(buf_count), .full(buf_full), .empty(buf_empty)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!(req_fire && pend_full));
      assert (!(imem_rsp_valid && pend_empty));
      assert (!(buf_push && buf_full && !buf_pop));
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized fetch traffic checked against an epoch-tagged request/delivery model
module tb_inst_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INST_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic stall = 1'b0;
  logic if_valid;
  logic [31:0] if_inst, if_pc;
  logic if_ready = 1'b0;
  always #5 clk = ~clk;
  inst_fetch #(.BUF_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready)
  );
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int epoch;
    int due;
  } mreq_t;
  mreq_t memq[$];
  logic [31:0] avail[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_addr[$];
  logic [31:0] exp_req_pc = RESET_PC;
  int epoch = 0, boot_cnt = 0, cyc = 0, boot_cyc = 0, total_deliv = 0;
  int first_rsp = -1, first_iv = -1, first_rv = -1;
  int n_cmp = 0, n_bad = 0;
  int unsigned p_stall = 0, p_ready = 100, p_ifr = 100, p_rsp = 100, lat_min = 1, lat_max = 1;
  bit armed = 1'b0, redir_done = 1'b0;
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction
  function automatic logic [31:0] lp(input int i);
    return i < log_pc.size() ? log_pc[i] : 32'bx;
  endfunction
  function automatic logic [31:0] la(input int i);
    return i < log_addr.size() ? log_addr[i] : 32'bx;
  endfunction
  function automatic logic [31:0] rand_pc();
    return ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : ($urandom & 32'h0000_0FFF);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference model: requests carry the redirect epoch they were issued in; only current-epoch responses are delivered
  always @(negedge clk) begin
    mreq_t h;
    bit kept, take, rv, iv, byp;
    logic [31:0] epc;
    if (reset) begin
      memq.delete();
      avail.delete();
      exp_req_pc = RESET_PC;
      boot_cnt = 0;
      epoch++;
      armed = 1'b1;
    end else if (armed) begin
      take = if_ready && !stall;
      h = '{default: 0};
      kept = 1'b0;
      if (imem_rsp_valid && memq.size() > 0) begin
        h = memq[0];
        kept = h.epoch == epoch && !redirect_valid;
      end
      rv = boot_cnt >= 1 && !stall && !redirect_valid && (memq.size() + avail.size() < DEPTH);
      byp = BYP && kept && take && avail.size() == 0;
      iv = !redirect_valid && (avail.size() > 0 || byp);
      epc = avail.size() > 0 ? avail[0] : h.pc;
      if (boot_cnt == 0) begin
        boot_cyc = cyc;
        chkb("boot_req_valid", imem_req_valid, 1'b0);
        chkb("boot_if_valid", if_valid, 1'b0);
        chk("boot_if_pc", if_pc, 32'h0);
        chk("boot_if_inst", if_inst, 32'h0);
        chk("boot_req_addr", imem_req_addr, RESET_PC);
      end
      chkb("req_valid", imem_req_valid, rv);
      chk("req_addr", imem_req_addr, exp_req_pc);
      chkb("if_valid", if_valid, iv);
      if (iv) begin
        chk("if_pc", if_pc, epc);
        chk("if_inst", if_inst, mw(epc));
      end
      if (imem_rsp_valid && first_rsp < 0) first_rsp = cyc;
      if (if_valid && first_iv < 0) first_iv = cyc;
      if (imem_req_valid && first_rv < 0) first_rv = cyc;
      if (if_valid && take) begin
        log_pc.push_back(if_pc);
        total_deliv++;
      end
      if (imem_req_valid && imem_req_ready) log_addr.push_back(imem_req_addr);
      if (imem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
      if (iv && take && !byp) void'(avail.pop_front());
      if (kept && !byp) avail.push_back(h.pc);
      if (imem_req_valid && imem_req_ready)
        memq.push_back('{addr: imem_req_addr, pc: exp_req_pc, epoch: epoch,
                         due: cyc + int'($urandom_range(lat_max, lat_min))});
      if (redirect_valid) begin
        avail.delete();
        epoch++;
        exp_req_pc = redirect_pc & ~32'h3;
      end else if (rv && imem_req_ready) exp_req_pc += 32'd4;
      boot_cnt++;
    end
  end
  task automatic tick(input bit rst_v, input int rmode, input logic [31:0] rpc);
    @(posedge clk);
    cyc++;
    #1;
    reset = rst_v;
    stall = $urandom_range(99) < p_stall;
    imem_req_ready = $urandom_range(99) < p_ready;
    if_ready = $urandom_range(99) < p_ifr;
    if (!rst_v && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mw(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    redirect_valid = rmode == 1 || (rmode == 2 && imem_rsp_valid);
    redirect_pc = rpc;
    if (redirect_valid) redir_done = 1'b1;
  endtask
  task automatic do_reset();
    tick(1'b1, 0, 32'h0);
    tick(1'b1, 0, 32'h0);
    log_pc.delete();
    log_addr.delete();
  endtask
  initial begin
    do_reset();
    first_rsp = -1;
    first_iv = -1;
    first_rv = -1;
    repeat (20) tick(1'b0, 0, 32'h0);
    chk("first_req_after_boot", first_rv - boot_cyc, 1);
    chk("rsp_to_if_valid", first_iv - first_rsp, BYP ? 0 : 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", la(i), RESET_PC + 32'(4 * i));
      chk("seq_pc", lp(i), RESET_PC + 32'(4 * i));
    end
    p_ifr = 0;
    repeat (5) tick(1'b0, 0, 32'h0);
    p_ifr = 100;
    repeat (10) tick(1'b0, 0, 32'h0);
    chkb("hold_release_count", log_pc.size() >= 10, 1'b1);
    for (int i = 0; i < log_pc.size(); i++) chk("hold_release_seq", log_pc[i], RESET_PC + 32'(4 * i));
    lat_min = 4;
    lat_max = 4;
    do_reset();
    for (int i = 0; i < 10 && memq.size() < 2; i++) tick(1'b0, 0, 32'h0);
    tick(1'b0, 1, 32'h0000_0100);
    log_pc.delete();
    repeat (20) tick(1'b0, 0, 32'h0);
    chk("flush_first_pc", lp(0), 32'h0000_0100);
    chk("flush_second_pc", lp(1), 32'h0000_0104);
    lat_min = 1;
    lat_max = 1;
    do_reset();
    repeat (6) tick(1'b0, 0, 32'h0);
    redir_done = 1'b0;
    for (int i = 0; i < 10 && !redir_done; i++) tick(1'b0, 2, 32'h0000_0202);
    log_pc.delete();
    repeat (12) tick(1'b0, 0, 32'h0);
    chk("redir_on_rsp_first_pc", lp(0), 32'h0000_0200);
    chk("redir_on_rsp_second_pc", lp(1), 32'h0000_0204);
    tick(1'b0, 1, 32'hFFFF_FFF8);
    log_addr.delete();
    log_pc.delete();
    repeat (12) tick(1'b0, 0, 32'h0);
    chk("wrap_addr0", la(0), 32'hFFFF_FFF8);
    chk("wrap_addr1", la(1), 32'hFFFF_FFFC);
    chk("wrap_addr2", la(2), 32'h0000_0000);
    chk("wrap_pc2", lp(2), 32'h0000_0000);
    tick(1'b1, 0, 32'h0);
    log_addr.delete();
    log_pc.delete();
    repeat (12) tick(1'b0, 0, 32'h0);
    chk("restart_addr", la(0), RESET_PC);
    chk("restart_pc", lp(0), RESET_PC);
    p_stall = 15;
    p_ready = 70;
    p_ifr = 70;
    p_rsp = 80;
    lat_min = 1;
    lat_max = 4;
    total_deliv = 0;
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(999) < 3, ($urandom_range(99) < 5) ? 1 : 0, rand_pc());
    chkb("random_progress", total_deliv > 200, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
